color_centroid: RTL and testbench
=================================

# color_centroid

Consumes the per-pixel colour-classification flags produced by the HSV threshold stage and reduces each video frame to one centroid per colour (blue, green). It accumulates pixel counts and coordinate sums during the active frame. At frame end it snapshots them and runs a shared sequential divider. It then presents registered centroids with a one-cycle valid pulse to the tracking/game logic downstream.

## Interface
- X_W, 11: width of hcount / x centroid.
- Y_W, 10: width of vcount / y centroid.
- CNT_W, 20: per-colour pixel counter width (covers 1024×768).
- SUM_W, 31: coordinate-sum width; both x and y sums use this width.
- MIN_PIXELS, 16: minimum count for a colour to be reported found.

Ports. One clock; reset is synchronous and active-high.
- clk  in  1  pixel/system clock.
- reset  in  1  synchronous, active-high.
- pixel_valid  in  1  current flags/coords belong to the active area.
- hcount  in  X_W  x of current pixel.
- vcount  in  Y_W  y of current pixel.
- is_blue  in  1  threshold flag.
- is_green  in  1  threshold flag.
- frame_end  in  1  one-cycle pulse on the last active pixel of a frame.
- blue_x / green_x  out  X_W  centroid x.
- blue_y / green_y  out  Y_W  centroid y.
- blue_found / green_found  out  1  count ≥ MIN_PIXELS for the last reported frame.
- centroid_valid  out  1  one-cycle pulse when all outputs have been updated.
- busy  out  1  divisions in progress.
- frame_dropped  out  1  one-cycle pulse when a frame_end is discarded.

## Operation
- Accumulation runs every cycle, in every FSM state:
  - pixel_valid && is_blue adds 1 to blue_cnt, hcount to blue_sx and vcount to blue_sy.
  - Green is handled the same way, independently.
  - A pixel flagged both blue and green counts in both.
- On frame_end, the current cycle's pixel is included. The totals are copied to a snapshot and the accumulators are cleared in the same edge, so the next frame starts clean.
- FSM states are IDLE, DIV_BX, DIV_BY, DIV_GX, DIV_GY, DONE.
  - IDLE moves to DIV_BX on frame_end.
  - Each DIV state issues start to the divider, waits for done, then advances.
  - DONE updates the outputs, pulses centroid_valid and returns to IDLE.
- Divisor is max(cnt,1), so division by zero never occurs. Quotients are truncated toward zero and take the low X_W/Y_W bits.
- found = (snapshot cnt ≥ MIN_PIXELS). When found=0, that colour's coordinates hold their previous value; the found flag still updates.
- frame_end while busy: the totals are discarded and the accumulators cleared. frame_dropped pulses and the in-flight division completes unaffected.
- Reset clears accumulators, snapshot, FSM (to IDLE) and divider. All outputs are 0 after reset, including the coordinates and flags. Reset mid-division produces no centroid_valid.

## Timing
- Divider: restoring, one quotient bit per cycle. It takes 1 load cycle plus SUM_W iterate cycles, giving DIV_CYC = SUM_W+1 = 32.
- The snapshot is registered at the frame_end edge, and the FSM issues the first start the following cycle.
- Latency is fixed and independent of counts or found status: with frame_end in cycle 0, centroid_valid is high in cycle 2+4·DIV_CYC = 130.
- busy is high from cycle 1 through cycle 130 inclusive.
- Outputs change only on the centroid_valid cycle and are stable otherwise.
- Widths:
  - Counters and sums saturate, never wrap. This cannot occur for ≤1024×768 at the default widths.
  - hcount and vcount are zero-extended into the sums.

## Structure
- A shared package holds the FSM state enum, the default widths, and DIV_CYC = SUM_W+1.
- Sub-module seq_divider (parameter W):
  - ports clk, reset, start, dividend[W], divisor[W];
  - outputs quotient[W] and a one-cycle done pulse.
- The parent holds the accumulators, snapshot, FSM and output registers.

## Test plan
- Single blue pixel at (100,50) with MIN_PIXELS=1, then frame_end → cycle 130: blue_x=100, blue_y=50, blue_found=1, green_found=0, green coords 0.
- Green 10×10 block at x 200..209, y 300..309 → green_x=204 (2045/10 truncated), green_y=304, green_found=1.
- Empty frame after a valid one → found flags 0, coordinates unchanged, centroid_valid still at cycle 130.
- Second frame_end at cycle 60 → frame_dropped pulse at 60. The first frame's results still arrive at cycle 130; the next frame_end is processed normally from clean accumulators.
- Full 1024×768 frame all blue and green → x=511, y=383 for both, no saturation flagged. Reset asserted at cycle 40 of the division → no centroid_valid, all outputs 0.
- MIN_PIXELS=4 with exactly 3 blue pixels → blue_found=0 and coordinates held; 4 pixels → found=1.

Source files
------------

// File: rtl/color_centroid_pkg.sv
// Shared types and default widths for the colour centroid block.
// Holds the FSM state enum and the divider latency constant.
package color_centroid_pkg;

    localparam int X_W_D        = 11;
    localparam int Y_W_D        = 10;
    localparam int CNT_W_D      = 20;
    localparam int SUM_W_D      = 31;
    localparam int MIN_PIXELS_D = 16;

    // One load cycle plus one cycle per quotient bit.
    localparam int DIV_CYC = SUM_W_D + 1;

    typedef enum logic [2:0] {
        IDLE,
        DIV_BX,
        DIV_BY,
        DIV_GX,
        DIV_GY,
        DONE
    } state_t;

endpackage

// File: rtl/color_centroid_divider.sv
// Restoring sequential divider, one quotient bit per cycle.
// Ports: clk, reset (sync, high), start, dividend, divisor -> quotient, done.
module seq_divider #(
    parameter int W = 31
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] quotient,
    output logic         done
);

    localparam int CW = $clog2(W + 1);

    // r_dq starts as the dividend; quotient bits shift in from the right.
    logic [W-1:0]  r_dq;
    logic [W-1:0]  r_dvs;
    logic [W-1:0]  r_rem;
    logic [CW-1:0] r_cnt;
    logic          r_run;

    logic [W:0]    w_sh;
    logic [W:0]    w_diff;
    logic          w_ge;
    logic [W-1:0]  w_rem_nx;
    logic          w_unused;

    assign w_sh     = {r_rem, r_dq[W-1]};
    assign w_ge     = (w_sh >= {1'b0, r_dvs});
    assign w_diff   = w_sh - {1'b0, r_dvs};
    assign w_rem_nx = w_ge ? w_diff[W-1:0] : w_sh[W-1:0];
    assign w_unused = &{1'b0, w_diff[W]};

    // The final quotient bit is presented combinationally with done,
    // so the whole division fits in load + W cycles.
    assign quotient = {r_dq[W-2:0], w_ge};
    assign done     = r_run && (r_cnt == CW'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_dq  <= '0;
            r_dvs <= '0;
            r_rem <= '0;
            r_cnt <= '0;
            r_run <= 1'b0;
        end else if (start) begin
            r_dq  <= dividend;
            r_dvs <= divisor;
            r_rem <= '0;
            r_cnt <= CW'(W);
            r_run <= 1'b1;
        end else if (r_run) begin
            r_dq  <= quotient;
            r_rem <= w_rem_nx;
            r_cnt <= r_cnt - CW'(1);
            if (r_cnt == CW'(1)) begin
                r_run <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/color_centroid.sv
// Per-frame blue/green centroid reduction from HSV threshold flags.
// In: clk, reset, pixel_valid, hcount, vcount, is_blue, is_green, frame_end.
// Out: blue_x/y, green_x/y, *_found, centroid_valid, busy, frame_dropped.
module color_centroid
    import color_centroid_pkg::*;
#(
    parameter int X_W        = X_W_D,
    parameter int Y_W        = Y_W_D,
    parameter int CNT_W      = CNT_W_D,
    parameter int SUM_W      = SUM_W_D,
    parameter int MIN_PIXELS = MIN_PIXELS_D
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           pixel_valid,
    input  logic [X_W-1:0] hcount,
    input  logic [Y_W-1:0] vcount,
    input  logic           is_blue,
    input  logic           is_green,
    input  logic           frame_end,
    output logic [X_W-1:0] blue_x,
    output logic [Y_W-1:0] blue_y,
    output logic [X_W-1:0] green_x,
    output logic [Y_W-1:0] green_y,
    output logic           blue_found,
    output logic           green_found,
    output logic           centroid_valid,
    output logic           busy,
    output logic           frame_dropped
);

    function automatic logic [SUM_W-1:0] sat_add(
        input logic [SUM_W-1:0] a,
        input logic [SUM_W-1:0] b
    );
        logic [SUM_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[SUM_W] ? '1 : s[SUM_W-1:0];
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(
        input logic [CNT_W-1:0] a
    );
        return (&a) ? a : a + CNT_W'(1);
    endfunction

    logic [CNT_W-1:0] r_bcnt, r_gcnt;
    logic [SUM_W-1:0] r_bsx, r_bsy, r_gsx, r_gsy;
    logic [CNT_W-1:0] w_bcnt_nx, w_gcnt_nx;
    logic [SUM_W-1:0] w_bsx_nx, w_bsy_nx, w_gsx_nx, w_gsy_nx;

    logic [CNT_W-1:0] r_snap_bcnt, r_snap_gcnt;
    logic [SUM_W-1:0] r_snap_bsx, r_snap_bsy;
    logic [SUM_W-1:0] r_snap_gsx, r_snap_gsy;

    state_t           r_state, w_state_nx;
    logic             r_issued;
    logic             w_start;
    logic             w_div_done;
    logic [SUM_W-1:0] w_dividend, w_divisor, w_quot;
    logic [SUM_W-1:0] w_bdvs, w_gdvs;

    logic [X_W-1:0]   r_q_bx, r_q_gx;
    logic [Y_W-1:0]   r_q_by, r_q_gy;

    logic             w_b_hit, w_g_hit;
    logic             w_busy, w_accept;
    logic             w_bfound, w_gfound;
    logic             w_unused;

    assign w_b_hit = pixel_valid & is_blue;
    assign w_g_hit = pixel_valid & is_green;

    // Totals including the current cycle's pixel.
    assign w_bcnt_nx = w_b_hit ? sat_inc(r_bcnt) : r_bcnt;
    assign w_bsx_nx  = w_b_hit ? sat_add(r_bsx, SUM_W'(hcount)) : r_bsx;
    assign w_bsy_nx  = w_b_hit ? sat_add(r_bsy, SUM_W'(vcount)) : r_bsy;
    assign w_gcnt_nx = w_g_hit ? sat_inc(r_gcnt) : r_gcnt;
    assign w_gsx_nx  = w_g_hit ? sat_add(r_gsx, SUM_W'(hcount)) : r_gsx;
    assign w_gsy_nx  = w_g_hit ? sat_add(r_gsy, SUM_W'(vcount)) : r_gsy;

    // busy covers the valid cycle too, so a frame_end there is dropped.
    assign w_busy        = (r_state != IDLE) | centroid_valid;
    assign w_accept      = frame_end & ~w_busy;
    assign busy          = w_busy;
    assign frame_dropped = frame_end & w_busy;

    assign w_bfound = (r_snap_bcnt >= CNT_W'(MIN_PIXELS));
    assign w_gfound = (r_snap_gcnt >= CNT_W'(MIN_PIXELS));

    assign w_bdvs = (r_snap_bcnt == '0) ? SUM_W'(1) : SUM_W'(r_snap_bcnt);
    assign w_gdvs = (r_snap_gcnt == '0) ? SUM_W'(1) : SUM_W'(r_snap_gcnt);

    assign w_unused = &{1'b0, w_quot[SUM_W-1:X_W]};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_bcnt <= '0;
            r_bsx  <= '0;
            r_bsy  <= '0;
            r_gcnt <= '0;
            r_gsx  <= '0;
            r_gsy  <= '0;
        end else if (frame_end) begin
            r_bcnt <= '0;
            r_bsx  <= '0;
            r_bsy  <= '0;
            r_gcnt <= '0;
            r_gsx  <= '0;
            r_gsy  <= '0;
        end else begin
            r_bcnt <= w_bcnt_nx;
            r_bsx  <= w_bsx_nx;
            r_bsy  <= w_bsy_nx;
            r_gcnt <= w_gcnt_nx;
            r_gsx  <= w_gsx_nx;
            r_gsy  <= w_gsy_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_snap_bcnt <= '0;
            r_snap_bsx  <= '0;
            r_snap_bsy  <= '0;
            r_snap_gcnt <= '0;
            r_snap_gsx  <= '0;
            r_snap_gsy  <= '0;
        end else if (w_accept) begin
            r_snap_bcnt <= w_bcnt_nx;
            r_snap_bsx  <= w_bsx_nx;
            r_snap_bsy  <= w_bsy_nx;
            r_snap_gcnt <= w_gcnt_nx;
            r_snap_gsx  <= w_gsx_nx;
            r_snap_gsy  <= w_gsy_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_start    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nx = DIV_BX;
                end
            end
            DIV_BX: begin
                w_start = ~r_issued;
                if (w_div_done) begin
                    w_state_nx = DIV_BY;
                end
            end
            DIV_BY: begin
                w_start = ~r_issued;
                if (w_div_done) begin
                    w_state_nx = DIV_GX;
                end
            end
            DIV_GX: begin
                w_start = ~r_issued;
                if (w_div_done) begin
                    w_state_nx = DIV_GY;
                end
            end
            DIV_GY: begin
                w_start = ~r_issued;
                if (w_div_done) begin
                    w_state_nx = DONE;
                end
            end
            DONE: begin
                w_state_nx = IDLE;
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
    end

    always_comb begin
        w_dividend = '0;
        w_divisor  = w_bdvs;
        unique case (r_state)
            DIV_BX: begin
                w_dividend = r_snap_bsx;
                w_divisor  = w_bdvs;
            end
            DIV_BY: begin
                w_dividend = r_snap_bsy;
                w_divisor  = w_bdvs;
            end
            DIV_GX: begin
                w_dividend = r_snap_gsx;
                w_divisor  = w_gdvs;
            end
            DIV_GY: begin
                w_dividend = r_snap_gsy;
                w_divisor  = w_gdvs;
            end
            default: begin
            end
        endcase
    end

    // One start per DIV state; cleared when the divider reports done.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_issued <= 1'b0;
        end else if (w_div_done) begin
            r_issued <= 1'b0;
        end else if (w_start) begin
            r_issued <= 1'b1;
        end
    end

    seq_divider #(
        .W(SUM_W)
    ) u_div (
        .clk      (clk),
        .reset    (reset),
        .start    (w_start),
        .dividend (w_dividend),
        .divisor  (w_divisor),
        .quotient (w_quot),
        .done     (w_div_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q_bx <= '0;
            r_q_by <= '0;
            r_q_gx <= '0;
            r_q_gy <= '0;
        end else if (w_div_done) begin
            unique case (r_state)
                DIV_BX:  r_q_bx <= w_quot[X_W-1:0];
                DIV_BY:  r_q_by <= w_quot[Y_W-1:0];
                DIV_GX:  r_q_gx <= w_quot[X_W-1:0];
                DIV_GY:  r_q_gy <= w_quot[Y_W-1:0];
                default: begin
                end
            endcase
        end
    end

    // Coordinates of a colour not found keep their previous value.
    always_ff @(posedge clk) begin
        if (reset) begin
            blue_x         <= '0;
            blue_y         <= '0;
            green_x        <= '0;
            green_y        <= '0;
            blue_found     <= 1'b0;
            green_found    <= 1'b0;
            centroid_valid <= 1'b0;
        end else begin
            centroid_valid <= 1'b0;
            if (r_state == DONE) begin
                centroid_valid <= 1'b1;
                blue_found     <= w_bfound;
                green_found    <= w_gfound;
                if (w_bfound) begin
                    blue_x <= r_q_bx;
                    blue_y <= r_q_by;
                end
                if (w_gfound) begin
                    green_x <= r_q_gx;
                    green_y <= r_q_gy;
                end
            end
        end
    end

endmodule

// File: tb/tb_color_centroid.sv
// Testbench for color_centroid: two instances (MIN_PIXELS 1 and 4)
// share stimulus; a queue scoreboard checks every centroid_valid.
module tb_color_centroid;
    import color_centroid_pkg::*;

    localparam int LAT = 4 * DIV_CYC + 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        pixel_valid;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic        is_blue;
    logic        is_green;
    logic        frame_end;

    logic [10:0] bx [2];
    logic [9:0]  by [2];
    logic [10:0] gx [2];
    logic [9:0]  gy [2];
    logic        bf [2];
    logic        gf [2];
    logic        cv [2];
    logic        bsy [2];
    logic        fd [2];

    color_centroid #(.MIN_PIXELS(1)) dut0 (
        .clk(clk), .reset(reset), .pixel_valid(pixel_valid),
        .hcount(hcount), .vcount(vcount), .is_blue(is_blue),
        .is_green(is_green), .frame_end(frame_end),
        .blue_x(bx[0]), .blue_y(by[0]), .green_x(gx[0]),
        .green_y(gy[0]), .blue_found(bf[0]), .green_found(gf[0]),
        .centroid_valid(cv[0]), .busy(bsy[0]),
        .frame_dropped(fd[0])
    );

    color_centroid #(.MIN_PIXELS(4)) dut4 (
        .clk(clk), .reset(reset), .pixel_valid(pixel_valid),
        .hcount(hcount), .vcount(vcount), .is_blue(is_blue),
        .is_green(is_green), .frame_end(frame_end),
        .blue_x(bx[1]), .blue_y(by[1]), .green_x(gx[1]),
        .green_y(gy[1]), .blue_found(bf[1]), .green_found(gf[1]),
        .centroid_valid(cv[1]), .busy(bsy[1]),
        .frame_dropped(fd[1])
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [10:0] bx;
        logic [9:0]  by;
        logic [10:0] gx;
        logic [9:0]  gy;
        logic        bf;
        logic        gf;
    } res_t;

    res_t q0[$];
    res_t q1[$];
    int   qc[$];
    res_t held [2];

    longint m_bc, m_bsx, m_bsy, m_gc, m_gsx, m_gsy;
    logic   last_drop0, last_drop1;

    // Monitor-side temporaries
    res_t e0, e1, a0, a1;
    int   fe_c;

    task automatic model_clear();
        m_bc = 0; m_bsx = 0; m_bsy = 0;
        m_gc = 0; m_gsx = 0; m_gsy = 0;
    endtask

    task automatic model_frame(input bit drop);
        res_t r;
        longint thr;
        if (!drop) begin
            for (int i = 0; i < 2; i++) begin
                thr = (i == 0) ? 1 : 4;
                r = held[i];
                r.bf = (m_bc >= thr);
                r.gf = (m_gc >= thr);
                if (r.bf) begin
                    r.bx = 11'(m_bsx / m_bc);
                    r.by = 10'(m_bsy / m_bc);
                end
                if (r.gf) begin
                    r.gx = 11'(m_gsx / m_gc);
                    r.gy = 10'(m_gsy / m_gc);
                end
                held[i] = r;
                if (i == 0) q0.push_back(r);
                else q1.push_back(r);
            end
            qc.push_back(cyc);
        end
        model_clear();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle of stimulus; frame_dropped is sampled mid-cycle.
    task automatic px(input bit pv, input int x, input int y,
                      input bit b, input bit g, input bit fe,
                      input bit drop);
        pixel_valid = pv;
        hcount = 11'(x);
        vcount = 10'(y);
        is_blue = b;
        is_green = g;
        frame_end = fe;
        if (pv && b) begin
            m_bc++; m_bsx += x; m_bsy += y;
        end
        if (pv && g) begin
            m_gc++; m_gsx += x; m_gsy += y;
        end
        if (fe) model_frame(drop);
        #1;
        last_drop0 = fd[0];
        last_drop1 = fd[1];
        tick();
        pixel_valid = 1'b0;
        is_blue = 1'b0;
        is_green = 1'b0;
        frame_end = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) px(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic wait_done(output bit ok);
        int n = 0;
        while (q0.size() != 0 && n < 400) begin
            idle(1);
            n++;
        end
        ok = (q0.size() == 0);
        if (!ok) begin
            q0.delete(); q1.delete(); qc.delete();
        end
    endtask

    always @(negedge clk) begin
        if (cv[0] === 1'b1 || cv[1] === 1'b1) begin
            checks++;
            if (cv[0] !== cv[1] || q0.size() == 0) begin
                failures++;
                $display("FAIL valid_unexpected cv0=%b cv1=%b pending=%0d",
                         cv[0], cv[1], q0.size());
                if (q0.size() != 0) begin
                    void'(q0.pop_front());
                    void'(q1.pop_front());
                    void'(qc.pop_front());
                end
            end else begin
                e0 = q0.pop_front();
                e1 = q1.pop_front();
                fe_c = qc.pop_front();
                a0 = {bx[0], by[0], gx[0], gy[0], bf[0], gf[0]};
                a1 = {bx[1], by[1], gx[1], gy[1], bf[1], gf[1]};
                checks++;
                if (cyc - fe_c !== LAT) begin
                    failures++;
                    $display("FAIL latency got=%0d exp=%0d", cyc - fe_c, LAT);
                end
                checks++;
                if (a0 !== e0) begin
                    failures++;
                    $display("FAIL result_min1 got bx=%0d by=%0d gx=%0d gy=%0d bf=%b gf=%b exp bx=%0d by=%0d gx=%0d gy=%0d bf=%b gf=%b",
                             a0.bx, a0.by, a0.gx, a0.gy, a0.bf, a0.gf,
                             e0.bx, e0.by, e0.gx, e0.gy, e0.bf, e0.gf);
                end
                checks++;
                if (a1 !== e1) begin
                    failures++;
                    $display("FAIL result_min4 got bx=%0d by=%0d gx=%0d gy=%0d bf=%b gf=%b exp bx=%0d by=%0d gx=%0d gy=%0d bf=%b gf=%b",
                             a1.bx, a1.by, a1.gx, a1.gy, a1.bf, a1.gf,
                             e1.bx, e1.by, e1.gx, e1.gy, e1.bf, e1.gf);
                end
            end
        end
    end

    task automatic test_reset();
        reset = 1'b1;
        idle(3);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({bx[i], by[i], gx[i], gy[i], bf[i], gf[i], cv[i], bsy[i]} !== '0) begin
                failures++;
                $display("FAIL reset_outputs inst=%0d got=%h exp=0", i,
                         {bx[i], by[i], gx[i], gy[i], bf[i], gf[i], cv[i], bsy[i]});
            end
        end
        reset = 1'b0;
        idle(2);
        checks++;
        if ({bsy[0], cv[0], bf[0], bx[0]} !== '0) begin
            failures++;
            $display("FAIL post_reset_idle got=%h exp=0", {bsy[0], cv[0], bf[0], bx[0]});
        end
    endtask

    task automatic test_single_blue();
        px(1, 100, 50, 1, 0, 0, 0);
        px(0, 300, 300, 1, 1, 0, 0);
        px(1, 5, 5, 0, 0, 0, 0);
        px(0, 0, 0, 0, 0, 1, 0);
        checks++;
        if (bsy[0] !== 1'b1 || bsy[1] !== 1'b1) begin
            failures++;
            $display("FAIL busy_cycle1 got=%b%b exp=11", bsy[0], bsy[1]);
        end
        idle(LAT - 2);
        checks++;
        if (cv[0] !== 1'b0 || bsy[0] !== 1'b1) begin
            failures++;
            $display("FAIL cycle129 got cv=%b busy=%b exp cv=0 busy=1", cv[0], bsy[0]);
        end
        idle(1);
        checks++;
        if (cv[0] !== 1'b1 || bsy[0] !== 1'b1) begin
            failures++;
            $display("FAIL cycle130 got cv=%b busy=%b exp cv=1 busy=1", cv[0], bsy[0]);
        end
        idle(1);
        checks++;
        if (cv[0] !== 1'b0 || bsy[0] !== 1'b0 || bx[0] !== 11'd100) begin
            failures++;
            $display("FAIL cycle131 got cv=%b busy=%b bx=%0d exp cv=0 busy=0 bx=100",
                     cv[0], bsy[0], bx[0]);
        end
    endtask

    task automatic test_green_block();
        bit ok;
        for (int y = 300; y < 310; y++)
            for (int x = 200; x < 210; x++)
                px(1, x, y, 0, 1, 0, 0);
        px(0, 0, 0, 0, 0, 1, 0);
        wait_done(ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL green_timeout got=none exp=centroid_valid");
        end
        checks++;
        if (gx[0] !== 11'd204 || gy[0] !== 10'd304 || gf[0] !== 1'b1) begin
            failures++;
            $display("FAIL green_block got gx=%0d gy=%0d gf=%b exp 204 304 1",
                     gx[0], gy[0], gf[0]);
        end
    endtask

    task automatic test_empty();
        bit ok;
        px(0, 0, 0, 0, 0, 1, 0);
        wait_done(ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL empty_timeout got=none exp=centroid_valid");
        end
    endtask

    task automatic test_drop();
        bit ok;
        for (int x = 10; x < 14; x++) px(1, x, 20, 1, 0, 0, 0);
        px(0, 0, 0, 0, 0, 1, 0);
        idle(29);
        px(1, 33, 44, 0, 1, 0, 0);
        idle(28);
        px(0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (last_drop0 !== 1'b0) begin
            failures++;
            $display("FAIL drop_cycle59 got=%b exp=0", last_drop0);
        end
        px(1, 900, 600, 1, 1, 1, 1);
        checks++;
        if (last_drop0 !== 1'b1 || last_drop1 !== 1'b1) begin
            failures++;
            $display("FAIL drop_cycle60 got=%b%b exp=11", last_drop0, last_drop1);
        end
        px(0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (last_drop0 !== 1'b0) begin
            failures++;
            $display("FAIL drop_cycle61 got=%b exp=0", last_drop0);
        end
        wait_done(ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL drop_first_timeout got=none exp=centroid_valid");
        end
        for (int i = 0; i < 5; i++) px(1, 7, 9, 0, 1, 0, 0);
        px(0, 0, 0, 0, 0, 1, 0);
        wait_done(ok);
        checks++;
        if (!ok || gx[1] !== 11'd7 || gy[1] !== 10'd9) begin
            failures++;
            $display("FAIL drop_next_frame got gx=%0d gy=%0d exp 7 9", gx[1], gy[1]);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        px(1, 1000, 700, 1, 0, 0, 0);
        px(1, 1002, 700, 1, 0, 1, 0);
        wait_done(ok);
        px(1, 3, 4, 0, 1, 1, 0);
        checks++;
        if (!ok || last_drop0 !== 1'b0 || bsy[0] !== 1'b1) begin
            failures++;
            $display("FAIL back_to_back got ok=%b drop=%b busy=%b exp 1 0 1",
                     ok, last_drop0, bsy[0]);
        end
        wait_done(ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL b2b_timeout got=none exp=centroid_valid");
        end
    endtask

    task automatic test_corner();
        bit ok;
        for (int y = 764; y < 768; y++)
            for (int x = 1020; x < 1024; x++)
                px(1, x, y, 1, 1, 0, 0);
        px(0, 0, 0, 0, 0, 1, 0);
        wait_done(ok);
        checks++;
        if (!ok || bx[1] !== 11'd1021 || by[1] !== 10'd765 ||
            gx[1] !== 11'd1021 || gy[1] !== 10'd765) begin
            failures++;
            $display("FAIL corner got %0d %0d %0d %0d exp 1021 765 1021 765",
                     bx[1], by[1], gx[1], gy[1]);
        end
    endtask

    task automatic test_threshold();
        bit ok;
        for (int x = 500; x < 503; x++) px(1, x, 400, 1, 0, 0, 0);
        px(0, 0, 0, 0, 0, 1, 0);
        wait_done(ok);
        checks++;
        if (!ok || bf[1] !== 1'b0 || bx[1] !== 11'd1021 || bf[0] !== 1'b1) begin
            failures++;
            $display("FAIL thresh3 got bf4=%b bx4=%0d bf1=%b exp 0 1021 1",
                     bf[1], bx[1], bf[0]);
        end
        for (int x = 600; x < 604; x++) px(1, x, 10, 1, 0, 0, 0);
        px(0, 0, 0, 0, 0, 1, 0);
        wait_done(ok);
        checks++;
        if (!ok || bf[1] !== 1'b1 || bx[1] !== 11'd601 || by[1] !== 10'd10) begin
            failures++;
            $display("FAIL thresh4 got bf=%b bx=%0d by=%0d exp 1 601 10",
                     bf[1], bx[1], by[1]);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        for (int i = 0; i < 4; i++) px(1, 50, 60, 0, 1, 0, 0);
        px(0, 0, 0, 0, 0, 1, 0);
        idle(39);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        q0.delete(); q1.delete(); qc.delete();
        held[0] = '0;
        held[1] = '0;
        model_clear();
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({bx[i], by[i], gx[i], gy[i], bf[i], gf[i], cv[i], bsy[i]} !== '0) begin
                failures++;
                $display("FAIL reset_mid inst=%0d got=%h exp=0", i,
                         {bx[i], by[i], gx[i], gy[i], bf[i], gf[i], cv[i], bsy[i]});
            end
        end
        idle(200);
        checks++;
        if (bsy[0] !== 1'b0 || bx[0] !== 11'd0) begin
            failures++;
            $display("FAIL reset_mid_quiet got busy=%b bx=%0d exp 0 0", bsy[0], bx[0]);
        end
        px(1, 100, 50, 1, 0, 1, 0);
        wait_done(ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL recover_timeout got=none exp=centroid_valid");
        end
    endtask

    initial begin
        reset = 1'b1;
        pixel_valid = 1'b0;
        hcount = '0;
        vcount = '0;
        is_blue = 1'b0;
        is_green = 1'b0;
        frame_end = 1'b0;
        held[0] = '0;
        held[1] = '0;
        model_clear();
        test_reset();
        test_single_blue();
        test_green_block();
        test_empty();
        test_drop();
        test_back_to_back();
        test_corner();
        test_threshold();
        test_reset_mid();
        idle(5);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
